axis_pkt_arbiter: RTL and testbench

Packet-granular round-robin arbiter that lets NUM_PORTS AXI-Stream producers share the write port of one axis_data_fifo instance. It selects one source, passes that source's whole packet (through tlast) to the FIFO, and tags every beat with the source index on tdest. Sits directly upstream of the FIFO's s_axis port, in the FIFO's write clock domain.

---
 rtl/axis_arb_pkg.sv | 15 +
 rtl/axis_rr_picker.sv | 29 ++
 rtl/axis_pkt_arbiter.sv | 148 ++++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet arbiter and related schedulers.
package axis_arb_pkg;

  // Arbiter FSM: waiting for a request, or passing one locked packet.
  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

  // Lowest bit of port `port` inside a packed per-port bus of `width`-bit slices.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin picker: first requester searching upward,
// modulo NUM_PORTS, starting just after last_grant.
module axis_rr_picker #(
  parameter  int NUM_PORTS  = 4,
  localparam int PORT_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [PORT_WIDTH-1:0] last_grant,
  output logic                  any,
  output logic [PORT_WIDTH-1:0] idx
);

  int cand;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = (int'(last_grant) + k) % NUM_PORTS;
      if (req[cand]) begin
        any = 1'b1;
        idx = PORT_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI-Stream FIFO write port.
// A grant locks one source until its tlast beat is accepted; every beat is
// tagged with the source index on tdest through one output register stage.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_PORTS   = 4,
  parameter  int TDATA_WIDTH = 32,
  parameter  int TUSER_WIDTH = 1,
  localparam int PORT_WIDTH  = $clog2(NUM_PORTS),
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                             s_aclk,
  input  logic                             s_areset,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic                             fifo_almost_full,
  output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic [PORT_WIDTH-1:0]            m_axis_tdest,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             grant_active,
  output logic [PORT_WIDTH-1:0]            grant_idx
);

  arb_state_t state_reg, state_next;

  logic [PORT_WIDTH-1:0]  grant_idx_reg, last_grant_reg, pick_idx;
  logic                   grant_active_reg, pick_any;
  logic                   grant_take, pkt_done;
  logic                   out_ready, accept;
  logic                   sel_valid, sel_last;
  logic [TDATA_WIDTH-1:0] sel_data;
  logic [TKEEP_WIDTH-1:0] sel_keep;
  logic [TUSER_WIDTH-1:0] sel_user;

  logic [TDATA_WIDTH-1:0] m_tdata_reg;
  logic [TKEEP_WIDTH-1:0] m_tkeep_reg;
  logic [TUSER_WIDTH-1:0] m_tuser_reg;
  logic [PORT_WIDTH-1:0]  m_tdest_reg;
  logic                   m_tlast_reg, m_tvalid_reg;

  axis_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req        (s_axis_tvalid),
    .last_grant (last_grant_reg),
    .any        (pick_any),
    .idx        (pick_idx)
  );

  // Select the granted port's beat and decide whether it moves this cycle.
  always_comb begin
    out_ready = !m_tvalid_reg || m_axis_tready;
    sel_valid = s_axis_tvalid[grant_idx_reg];
    sel_last  = s_axis_tlast[grant_idx_reg];
    sel_data  = s_axis_tdata[slice_lo(int'(grant_idx_reg), TDATA_WIDTH) +: TDATA_WIDTH];
    sel_keep  = s_axis_tkeep[slice_lo(int'(grant_idx_reg), TKEEP_WIDTH) +: TKEEP_WIDTH];
    sel_user  = s_axis_tuser[slice_lo(int'(grant_idx_reg), TUSER_WIDTH) +: TUSER_WIDTH];
    accept    = (state_reg == PASS) && out_ready && sel_valid;
  end

  // Only the locked port sees ready, and only when the output slot can take a beat.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
      assign s_axis_tready[gi] = (state_reg == PASS) &&
                                 (grant_idx_reg == PORT_WIDTH'(gi)) && out_ready;
    end
  endgenerate

  // Next-state: grant only from IDLE with FIFO headroom; release on accepted tlast.
  always_comb begin
    state_next = state_reg;
    grant_take = 1'b0;
    pkt_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_any && !fifo_almost_full) begin
          state_next = PASS;
          grant_take = 1'b1;
        end
      end
      PASS: begin
        if (accept && sel_last) begin
          state_next = IDLE;
          pkt_done   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and grant bookkeeping.
  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      state_reg        <= IDLE;
      grant_idx_reg    <= '0;
      last_grant_reg   <= PORT_WIDTH'(NUM_PORTS - 1);
      grant_active_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_take) begin
        grant_idx_reg    <= pick_idx;
        grant_active_reg <= 1'b1;
      end
      if (pkt_done) begin
        last_grant_reg   <= grant_idx_reg;
        grant_active_reg <= 1'b0;
      end
    end
  end

  // Output register: loads on an accepted beat, otherwise drains on m_axis_tready.
  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      m_tdata_reg  <= '0;
      m_tkeep_reg  <= '0;
      m_tuser_reg  <= '0;
      m_tdest_reg  <= '0;
      m_tlast_reg  <= 1'b0;
      m_tvalid_reg <= 1'b0;
    end else if (accept) begin
      m_tdata_reg  <= sel_data;
      m_tkeep_reg  <= sel_keep;
      m_tuser_reg  <= sel_user;
      m_tdest_reg  <= grant_idx_reg;
      m_tlast_reg  <= sel_last;
      m_tvalid_reg <= 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_reg <= 1'b0;
    end
  end

  assign m_axis_tdata  = m_tdata_reg;
  assign m_axis_tkeep  = m_tkeep_reg;
  assign m_axis_tuser  = m_tuser_reg;
  assign m_axis_tdest  = m_tdest_reg;
  assign m_axis_tlast  = m_tlast_reg;
  assign m_axis_tvalid = m_tvalid_reg;
  assign grant_active  = grant_active_reg;
  assign grant_idx     = grant_idx_reg;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: per-port beat queues drive the inputs,
// accepted beats go to a scoreboard, and m-side beats are popped and compared.
module tb_axis_pkt_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 1;
  localparam int PW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              s_areset = 1'b1;
  logic [NP*DW-1:0]  s_axis_tdata = '0;
  logic [NP*KW-1:0]  s_axis_tkeep = '0;
  logic [NP*UW-1:0]  s_axis_tuser = '0;
  logic [NP-1:0]     s_axis_tlast = '0;
  logic [NP-1:0]     s_axis_tvalid = '0;
  logic [NP-1:0]     s_axis_tready;
  logic              fifo_almost_full = 1'b0;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic [UW-1:0]     m_axis_tuser;
  logic [PW-1:0]     m_axis_tdest;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              grant_active;
  logic [PW-1:0]     grant_idx;

  axis_pkt_arbiter #(.NUM_PORTS(NP), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .s_aclk           (clk),
    .s_areset         (s_areset),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .fifo_almost_full (fifo_almost_full),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tuser     (m_axis_tuser),
    .m_axis_tdest     (m_axis_tdest),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .grant_active     (grant_active),
    .grant_idx        (grant_idx)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          user;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          user;
    logic          last;
    logic [PW-1:0] dest;
  } exp_t;

  beat_t pq [NP][$];
  exp_t  sb [$];
  int    done_q [$];

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    pkt_id = 0;
  int    first_v = -1;
  int    last_c = -1;
  logic  mr = 1'b1;
  logic  af = 1'b0;
  logic  rst_v = 1'b1;
  logic  prev_stall = 1'b0;
  exp_t  prev_m = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int port, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {8'(port), 8'(pkt_id), 8'(i), 8'hC3};
      b.keep = (i == nbeats - 1) ? 4'h7 : 4'hF;
      b.user = i[0];
      b.last = (i == nbeats - 1);
      pq[port].push_back(b);
    end
    pkt_id++;
  endtask

  function automatic logic busy();
    logic r;
    r = m_axis_tvalid || (sb.size() > 0);
    for (int p = 0; p < NP; p++)
      if (pq[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  // One clock: drive at negedge, sample before posedge, book-keep after posedge.
  task automatic tick();
    int   acc;
    logic m_hs;
    exp_t cur, e;
    @(negedge clk);
    s_areset         = rst_v;
    m_axis_tready    = mr;
    fifo_almost_full = af;
    s_axis_tvalid    = '0;
    s_axis_tlast     = '0;
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() > 0) begin
        s_axis_tdata[p*DW +: DW] = pq[p][0].data;
        s_axis_tkeep[p*KW +: KW] = pq[p][0].keep;
        s_axis_tuser[p]          = pq[p][0].user;
        s_axis_tlast[p]          = pq[p][0].last;
        s_axis_tvalid[p]         = 1'b1;
      end
    end
    #1;
    cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tdest};
    if (!rst_v) begin
      check("ready_onehot", 64'($countones(s_axis_tready) <= 1), 64'd1);
      if (prev_stall) check("stall_hold", {m_axis_tvalid, cur}, {1'b1, prev_m});
      if (m_axis_tvalid && !m_axis_tready) check("stall_ready", s_axis_tready, 0);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready && !rst_v;
    prev_m     = cur;
    acc = -1;
    for (int p = 0; p < NP; p++)
      if (s_axis_tvalid[p] && s_axis_tready[p]) acc = p;
    m_hs = m_axis_tvalid && m_axis_tready;
    if (m_axis_tvalid && first_v < 0) first_v = cyc;
    @(posedge clk);
    cyc++;
    if (!rst_v) begin
      if (m_hs) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {1'b1, cur}, 0);
        end else begin
          e = sb.pop_front();
          check("m_beat", cur, e);
          if (cur.last) begin
            done_q.push_back(int'(cur.dest));
            last_c = cyc - 1;
          end
        end
      end
      if (acc >= 0) begin
        sb.push_back({pq[acc][0], 2'(acc)});
        void'(pq[acc].pop_front());
      end
    end
    #1;
  endtask

  task automatic run_done(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", busy(), 0);
  endtask

  task automatic flush_all();
    sb.delete();
    done_q.delete();
    for (int p = 0; p < NP; p++) pq[p].delete();
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    tick();
    tick();
    flush_all();
    rst_v = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tlast"},  m_axis_tlast, 0);
    check({tag, "_tdata"},  m_axis_tdata, 0);
    check({tag, "_tkeep"},  m_axis_tkeep, 0);
    check({tag, "_tuser"},  m_axis_tuser, 0);
    check({tag, "_tdest"},  m_axis_tdest, 0);
    check({tag, "_gactive"}, grant_active, 0);
    check({tag, "_gidx"},   grant_idx, 0);
    check({tag, "_sready"}, s_axis_tready, 0);
  endtask

  int exp_rr [8];

  initial begin
    // Reset state.
    do_reset();
    check_reset_outputs("reset");

    // Two simultaneous 3-beat packets on ports 0 and 2.
    add_pkt(0, 3);
    add_pkt(2, 3);
    first_v = -1;
    tick();
    check("t1_grant_idx", grant_idx, 0);
    check("t1_grant_active", grant_active, 1);
    check("t1_sready", s_axis_tready, 4'b0001);
    check("t1_mvalid_early", m_axis_tvalid, 0);
    run_done(50);
    check("t1_npkts", done_q.size(), 2);
    check("t1_order0", done_q[0], 0);
    check("t1_order1", done_q[1], 2);
    check("t1_span", last_c - first_v + 1, 7);

    // All four ports hold two 2-beat packets: strict rotation expected.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) add_pkt(p, 2);
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    run_done(200);
    check("t2_npkts", done_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("t2_order%0d", i), done_q[i], exp_rr[i]);
    done_q.delete();

    // Five-cycle stall mid-packet on port 1.
    add_pkt(1, 4);
    tick();
    tick();
    tick();
    mr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t3_sready_stall", s_axis_tready, 0);
    mr = 1'b1;
    run_done(50);
    check("t3_npkts", done_q.size(), 1);
    check("t3_order0", done_q[0], 1);
    done_q.delete();

    // Almost-full blocks new grants but not a locked packet.
    af = 1'b1;
    add_pkt(1, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_blocked_active", grant_active, 0);
      check("t4_blocked_sready", s_axis_tready, 0);
    end
    af = 1'b0;
    tick();
    check("t4_grant_active", grant_active, 1);
    check("t4_grant_idx", grant_idx, 1);
    af = 1'b1;
    run_done(50);
    check("t4_npkts", done_q.size(), 1);
    af = 1'b0;
    done_q.delete();

    // Single-beat packet on port 3, then port 0 wins the next grant.
    add_pkt(3, 1);
    tick();
    check("t5_grant_idx3", grant_idx, 3);
    check("t5_active_on", grant_active, 1);
    tick();
    check("t5_active_off", grant_active, 0);
    check("t5_grant_hold", grant_idx, 3);
    add_pkt(0, 2);
    tick();
    check("t5_grant_idx0", grant_idx, 0);
    run_done(50);
    check("t5_npkts", done_q.size(), 2);
    check("t5_order0", done_q[0], 3);
    check("t5_order1", done_q[1], 0);
    done_q.delete();

    // Reset during beat 2 of a 4-beat packet on port 2.
    add_pkt(2, 4);
    tick();
    check("t6_grant_idx2", grant_idx, 2);
    tick();
    rst_v = 1'b1;
    tick();
    check_reset_outputs("t6_reset");
    flush_all();
    rst_v = 1'b0;
    add_pkt(3, 2);
    add_pkt(0, 2);
    tick();
    check("t6_regrant_idx", grant_idx, 0);
    check("t6_regrant_active", grant_active, 1);
    run_done(50);
    check("t6_npkts", done_q.size(), 2);
    check("t6_order0", done_q[0], 0);
    check("t6_order1", done_q[1], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
